// File: rtl/insn_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch unit with prefetch queue.
package insn_fetch_queue_pkg;

    localparam int unsigned IFQ_LEN_INSN      = 32;
    localparam int unsigned IFQ_MEM_INSN_ADDR = 10;
    localparam int unsigned IFQ_DEPTH         = 4;

    // Fetch mode; FLUSH marks the cycle after a redirect
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    // Reserved for tagging why a redirect happened
    typedef enum logic [1:0] {
        RD_NONE      = 2'd0,
        RD_BRANCH    = 2'd1,
        RD_JUMP      = 2'd2,
        RD_EXCEPTION = 2'd3
    } redirect_reason_e;

    // Occupancy counter width for a queue of the given depth
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/insn_fetch_queue_if.sv
// Fetch unit bus bundle: control, instruction memory port and decode handshake.
interface insn_fetch_queue_if #(
    parameter int unsigned LEN_INSN      = insn_fetch_queue_pkg::IFQ_LEN_INSN,
    parameter int unsigned MEM_INSN_ADDR = insn_fetch_queue_pkg::IFQ_MEM_INSN_ADDR,
    parameter int unsigned DEPTH         = insn_fetch_queue_pkg::IFQ_DEPTH
) ();

    localparam int unsigned CNT_W = insn_fetch_queue_pkg::cnt_width(DEPTH);

    logic                     en_i;
    logic                     redirect_i;
    logic [MEM_INSN_ADDR-1:0] redirect_addr_i;
    logic                     mem_rd_o;
    logic [MEM_INSN_ADDR-1:0] mem_addr_o;
    logic [LEN_INSN-1:0]      mem_q_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [LEN_INSN-1:0]      insn_o;
    logic [MEM_INSN_ADDR-1:0] addr_o;
    logic [CNT_W-1:0]         count_o;

    // Fetch unit side
    modport master (
        input  en_i, redirect_i, redirect_addr_i, mem_q_i, ready_i,
        output mem_rd_o, mem_addr_o, valid_o, insn_o, addr_o, count_o
    );

    // Memory / decode / control side
    modport slave (
        output en_i, redirect_i, redirect_addr_i, mem_q_i, ready_i,
        input  mem_rd_o, mem_addr_o, valid_o, insn_o, addr_o, count_o
    );

endinterface

// File: rtl/insn_fetch_queue_fetch_fifo.sv
// Prefetch queue: DEPTH x WIDTH circular buffer with push/pop/flush and head view.
module insn_fetch_queue_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 42
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage; cleared on reset so the head reads zero before the first fill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy; flush wins over push/pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Credit logic upstream must never overfill or underflow the queue
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (push && !pop && !flush) |-> (count_q < CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        (pop && !flush) |-> (count_q != '0));

endmodule

// File: rtl/insn_fetch_queue.sv
// Instruction fetch unit: pc, single in-flight read tracking, credit-based issue
// into a prefetch queue, redirect flush and decode valid/ready handshake.
// Optional build macro INSN_FETCH_BYPASS_EN forwards a return straight to decode
// when the queue is empty (one cycle less latency).
module insn_fetch_queue #(
    parameter int unsigned              LEN_INSN      = insn_fetch_queue_pkg::IFQ_LEN_INSN,
    parameter int unsigned              MEM_INSN_ADDR = insn_fetch_queue_pkg::IFQ_MEM_INSN_ADDR,
    parameter int unsigned              DEPTH         = insn_fetch_queue_pkg::IFQ_DEPTH,
    parameter logic [MEM_INSN_ADDR-1:0] RESET_ADDR    = '0
) (
    input logic                clk,
    input logic                rst,
    insn_fetch_queue_if.master bus
);

    import insn_fetch_queue_pkg::*;

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam int unsigned ENT_W = LEN_INSN + MEM_INSN_ADDR;

    logic [MEM_INSN_ADDR-1:0] pc_q;
    logic [MEM_INSN_ADDR-1:0] inflight_addr_q;
    logic                     inflight_q;
    fetch_state_e             state_q;

    logic [CNT_W-1:0]         fifo_count;
    logic [ENT_W-1:0]         fifo_head;
    logic                     ret_c;
    logic                     fifo_pop_c;
    logic                     fifo_push_c;
    logic                     issue_c;
    logic [CRD_W-1:0]         credit_c;

    // A return is live unless a redirect kills it this cycle
    assign ret_c      = inflight_q & ~bus.redirect_i;
    assign fifo_pop_c = bus.ready_i & (fifo_count != '0) & ~bus.redirect_i;

`ifdef INSN_FETCH_BYPASS_EN
    logic bypass_c;
    // Empty queue: show the returning word directly; consumed if decode is ready
    assign bypass_c    = ret_c & (fifo_count == '0);
    assign fifo_push_c = ret_c & ~(bypass_c & bus.ready_i);
`else
    assign fifo_push_c = ret_c;
`endif

    // Outstanding words with this cycle's pop already credited back
    assign credit_c = CRD_W'(fifo_count) + CRD_W'(inflight_q) - CRD_W'(fifo_pop_c);
    assign issue_c  = rst & bus.en_i & ~bus.redirect_i & (credit_c < CRD_W'(DEPTH));

    // Program counter and in-flight read tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q            <= RESET_ADDR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else if (bus.redirect_i) begin
            pc_q       <= bus.redirect_addr_i;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            if (issue_c) begin
                pc_q            <= pc_q + MEM_INSN_ADDR'(1);
                inflight_addr_q <= pc_q;
            end
        end
    end

    // Fetch mode tracker: any -> FLUSH on redirect, otherwise RUN/HOLD by enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HOLD;
        end else if (bus.redirect_i) begin
            state_q <= ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN, ST_HOLD, ST_FLUSH: state_q <= bus.en_i ? ST_RUN : ST_HOLD;
                default:                   state_q <= ST_HOLD;
            endcase
        end
    end

    insn_fetch_queue_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .flush (bus.redirect_i),
        .din   ({bus.mem_q_i, inflight_addr_q}),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign bus.mem_rd_o   = issue_c;
    assign bus.mem_addr_o = pc_q;
    assign bus.count_o    = fifo_count;

`ifdef INSN_FETCH_BYPASS_EN
    assign bus.valid_o = (fifo_count != '0) | bypass_c;
    assign bus.insn_o  = bypass_c ? bus.mem_q_i : fifo_head[ENT_W-1:MEM_INSN_ADDR];
    assign bus.addr_o  = bypass_c ? inflight_addr_q : fifo_head[MEM_INSN_ADDR-1:0];
`else
    assign bus.valid_o = (fifo_count != '0);
    assign bus.insn_o  = fifo_head[ENT_W-1:MEM_INSN_ADDR];
    assign bus.addr_o  = fifo_head[MEM_INSN_ADDR-1:0];
`endif

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Directed bench for insn_fetch_queue: reset, streaming, stall/backpressure,
// redirect flush, address wrap, enable gating and mid-stream async reset.
`timescale 1ns/1ps
module tb_insn_fetch_queue;

    import insn_fetch_queue_pkg::*;

    localparam int unsigned LEN   = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;
    localparam logic [AW-1:0] RST_A = 10'h010;

`ifdef INSN_FETCH_BYPASS_EN
    localparam int         FIRST      = 1;
    localparam logic [2:0] STEADY_CNT = 3'd0;
`else
    localparam int         FIRST      = 2;
    localparam logic [2:0] STEADY_CNT = 3'd1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    insn_fetch_queue_if #(.LEN_INSN(LEN), .MEM_INSN_ADDR(AW), .DEPTH(DEPTH)) bus ();

    insn_fetch_queue #(
        .LEN_INSN      (LEN),
        .MEM_INSN_ADDR (AW),
        .DEPTH         (DEPTH),
        .RESET_ADDR    (RST_A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return 32'h5A00_0000 | {22'd0, a};
    endfunction

    // Synchronous-read instruction memory, one cycle latency
    always @(posedge clk) begin
        if (bus.mem_rd_o) bus.mem_q_i <= word(bus.mem_addr_o);
    end

    task automatic step(input logic en, input logic rdy);
        @(posedge clk);
        #2;
        bus.redirect_i = 1'b0;
        bus.en_i       = en;
        bus.ready_i    = rdy;
        #1;
    endtask

    task automatic redirect_step(input logic [AW-1:0] a, input logic en, input logic rdy);
        @(posedge clk);
        #2;
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = a;
        bus.en_i            = en;
        bus.ready_i         = rdy;
        #1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] ea;
        rst = 1'b1;
        bus.en_i = 1'b1; bus.ready_i = 1'b1;
        bus.redirect_i = 1'b0; bus.redirect_addr_i = '0;
        #1 rst = 1'b0;
        #2;
        total_cnt++; if (bus.valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.valid_o); else pass_cnt++;
        total_cnt++; if (bus.mem_rd_o !== 1'b0) $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd_o); else pass_cnt++;
        total_cnt++; if (bus.mem_addr_o !== RST_A) $display("FAIL rst_mem_addr: got %h want %h", bus.mem_addr_o, RST_A); else pass_cnt++;
        total_cnt++; if (bus.count_o !== 3'd0) $display("FAIL rst_count: got %0d want 0", bus.count_o); else pass_cnt++;
        total_cnt++; if (bus.insn_o !== 32'd0) $display("FAIL rst_insn: got %h want 0", bus.insn_o); else pass_cnt++;
        total_cnt++; if (bus.addr_o !== 10'd0) $display("FAIL rst_addr: got %h want 0", bus.addr_o); else pass_cnt++;
        #4 rst = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(1'b1, 1'b1);
            ea = RST_A + AW'(k);
            total_cnt++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== ea)
                $display("FAIL stream_issue c%0d: got rd=%b a=%h want rd=1 a=%h", k, bus.mem_rd_o, bus.mem_addr_o, ea);
                else pass_cnt++;
            total_cnt++; if (bus.valid_o !== (k >= FIRST))
                $display("FAIL stream_valid c%0d: got %b want %b", k, bus.valid_o, (k >= FIRST)); else pass_cnt++;
            if (k >= FIRST) begin
                ea = RST_A + AW'(k - FIRST);
                total_cnt++; if (bus.addr_o !== ea || bus.insn_o !== word(ea))
                    $display("FAIL stream_head c%0d: got a=%h i=%h want a=%h i=%h", k, bus.addr_o, bus.insn_o, ea, word(ea));
                    else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        logic [2:0]    ec;
        logic [AW-1:0] ea;
        redirect_step(10'h010, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0);
            ec = (c < 1) ? 3'd0 : ((c - 1 > 4) ? 3'd4 : 3'(c - 1));
            ea = 10'h010 + AW'((c > 4) ? 4 : c);
            total_cnt++; if (bus.count_o !== ec)
                $display("FAIL stall_count c%0d: got %0d want %0d", c, bus.count_o, ec); else pass_cnt++;
            total_cnt++; if (bus.mem_rd_o !== (c <= 3) || bus.mem_addr_o !== ea)
                $display("FAIL stall_issue c%0d: got rd=%b a=%h want rd=%b a=%h", c, bus.mem_rd_o, bus.mem_addr_o, (c <= 3), ea);
                else pass_cnt++;
            if (c >= 2) begin
                total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== 10'h010 || bus.insn_o !== word(10'h010))
                    $display("FAIL stall_hold c%0d: got v=%b a=%h i=%h want v=1 a=010", c, bus.valid_o, bus.addr_o, bus.insn_o);
                    else pass_cnt++;
            end
        end
        step(1'b1, 1'b1);
        total_cnt++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 10'h014)
            $display("FAIL release_issue: got rd=%b a=%h want rd=1 a=014", bus.mem_rd_o, bus.mem_addr_o); else pass_cnt++;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) step(1'b1, 1'b1);
            ea = 10'h010 + AW'(j);
            total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== ea || bus.insn_o !== word(ea))
                $display("FAIL release_seq j%0d: got v=%b a=%h want v=1 a=%h", j, bus.valid_o, bus.addr_o, ea); else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        logic [AW-1:0] ea;
        redirect_step(10'h010, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b0);
        redirect_step(10'h200, 1'b1, 1'b0);
        total_cnt++; if (bus.count_o !== 3'd3 || bus.mem_rd_o !== 1'b0)
            $display("FAIL redir_pre: got cnt=%0d rd=%b want cnt=3 rd=0", bus.count_o, bus.mem_rd_o); else pass_cnt++;
        step(1'b1, 1'b1);
        total_cnt++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0)
            $display("FAIL redir_flush: got cnt=%0d v=%b want cnt=0 v=0", bus.count_o, bus.valid_o); else pass_cnt++;
        total_cnt++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 10'h200)
            $display("FAIL redir_issue: got rd=%b a=%h want rd=1 a=200", bus.mem_rd_o, bus.mem_addr_o); else pass_cnt++;
        for (int f = 1; f < 5; f++) begin
            step(1'b1, 1'b1);
            if (f >= FIRST) begin
                ea = 10'h200 + AW'(f - FIRST);
                total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== ea || bus.insn_o !== word(ea))
                    $display("FAIL redir_seq f%0d: got v=%b a=%h i=%h want a=%h", f, bus.valid_o, bus.addr_o, bus.insn_o, ea);
                    else pass_cnt++;
            end else begin
                total_cnt++; if (bus.valid_o !== 1'b0)
                    $display("FAIL redir_stale f%0d: got v=%b want 0", f, bus.valid_o); else pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] ea;
        redirect_step(10'h3FE, 1'b1, 1'b1);
        for (int f = 0; f < 6; f++) begin
            step(1'b1, 1'b1);
            ea = 10'h3FE + AW'(f);
            total_cnt++; if (bus.mem_addr_o !== ea)
                $display("FAIL wrap_pc f%0d: got %h want %h", f, bus.mem_addr_o, ea); else pass_cnt++;
            if (f >= FIRST) begin
                ea = 10'h3FE + AW'(f - FIRST);
                total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== ea)
                    $display("FAIL wrap_head f%0d: got v=%b a=%h want a=%h", f, bus.valid_o, bus.addr_o, ea); else pass_cnt++;
            end
        end
    endtask

    task automatic test_redirect_pop();
        logic [AW-1:0] ea;
        redirect_step(10'h100, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) step(1'b1, 1'b1);
        total_cnt++; if (bus.count_o !== STEADY_CNT || bus.valid_o !== 1'b1)
            $display("FAIL rpop_pre: got cnt=%0d v=%b want cnt=%0d v=1", bus.count_o, bus.valid_o, STEADY_CNT); else pass_cnt++;
        redirect_step(10'h300, 1'b1, 1'b1);
        total_cnt++; if (bus.mem_rd_o !== 1'b0)
            $display("FAIL rpop_noissue: got rd=%b want 0", bus.mem_rd_o); else pass_cnt++;
        step(1'b1, 1'b1);
        total_cnt++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0 || bus.mem_addr_o !== 10'h300)
            $display("FAIL rpop_flush: got cnt=%0d v=%b a=%h want 0 0 300", bus.count_o, bus.valid_o, bus.mem_addr_o);
            else pass_cnt++;
        for (int f = 1; f < 4; f++) begin
            step(1'b1, 1'b1);
            if (f >= FIRST) begin
                ea = 10'h300 + AW'(f - FIRST);
                total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== ea)
                    $display("FAIL rpop_seq f%0d: got v=%b a=%h want a=%h", f, bus.valid_o, bus.addr_o, ea); else pass_cnt++;
            end
        end
    endtask

    task automatic test_enable();
        logic [AW-1:0] ea;
        redirect_step(10'h050, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1);
            total_cnt++; if (bus.mem_rd_o !== 1'b0 || bus.mem_addr_o !== 10'h050 || bus.count_o !== 3'd0)
                $display("FAIL en_low c%0d: got rd=%b a=%h cnt=%0d want 0 050 0", c, bus.mem_rd_o, bus.mem_addr_o, bus.count_o);
                else pass_cnt++;
        end
        step(1'b1, 1'b1);
        total_cnt++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== 10'h050)
            $display("FAIL en_resume: got rd=%b a=%h want 1 050", bus.mem_rd_o, bus.mem_addr_o); else pass_cnt++;
        for (int f = 1; f < 4; f++) begin
            step(1'b1, 1'b1);
            if (f >= FIRST) begin
                ea = 10'h050 + AW'(f - FIRST);
                total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== ea)
                    $display("FAIL en_seq f%0d: got v=%b a=%h want a=%h", f, bus.valid_o, bus.addr_o, ea); else pass_cnt++;
            end
        end
        step(1'b0, 1'b0);
        total_cnt++; if (bus.mem_rd_o !== 1'b0)
            $display("FAIL en_off_issue: got rd=%b want 0", bus.mem_rd_o); else pass_cnt++;
        step(1'b0, 1'b0);
        total_cnt++; if (bus.count_o !== STEADY_CNT + 3'd1)
            $display("FAIL en_off_return: got cnt=%0d want %0d", bus.count_o, STEADY_CNT + 3'd1); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] ea;
        redirect_step(10'h010, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0);
        total_cnt++; if (bus.count_o !== 3'd4 || bus.valid_o !== 1'b1)
            $display("FAIL arst_full: got cnt=%0d v=%b want 4 1", bus.count_o, bus.valid_o); else pass_cnt++;
        #1 rst = 1'b0;
        #1;
        total_cnt++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0 || bus.mem_rd_o !== 1'b0)
            $display("FAIL arst_now: got cnt=%0d v=%b rd=%b want 0 0 0", bus.count_o, bus.valid_o, bus.mem_rd_o); else pass_cnt++;
        total_cnt++; if (bus.mem_addr_o !== RST_A)
            $display("FAIL arst_pc: got %h want %h", bus.mem_addr_o, RST_A); else pass_cnt++;
        @(posedge clk);
        #2;
        rst = 1'b1; bus.en_i = 1'b1; bus.ready_i = 1'b1; bus.redirect_i = 1'b0;
        #1;
        total_cnt++; if (bus.mem_rd_o !== 1'b1 || bus.mem_addr_o !== RST_A)
            $display("FAIL arst_restart: got rd=%b a=%h want 1 %h", bus.mem_rd_o, bus.mem_addr_o, RST_A); else pass_cnt++;
        for (int k = 1; k < 5; k++) begin
            step(1'b1, 1'b1);
            if (k >= FIRST) begin
                ea = RST_A + AW'(k - FIRST);
                total_cnt++; if (bus.valid_o !== 1'b1 || bus.addr_o !== ea)
                    $display("FAIL arst_seq k%0d: got v=%b a=%h want a=%h", k, bus.valid_o, bus.addr_o, ea); else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_wrap();
        test_redirect_pop();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
